btn_evt_serializer: RTL

BTN_EVT_SERIALIZER -- requirements
Module: btn_evt_serializer

---
 rtl/btn_evt_pkg.sv | 28 ++
 rtl/btn_evt_fifo.sv | 58 +++++
 rtl/btn_evt_serializer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/btn_evt_pkg.sv
// Shared constants for the button-event serializer: button count, FSM encoding and
// the character table that maps a button index to its ASCII release character.
package btn_evt_pkg;

  localparam int unsigned NBTN  = 16;
  localparam int unsigned IDX_W = $clog2(NBTN);
  // One report is {state, change}, each NBTN bits wide.
  localparam int unsigned RPT_W = 2 * NBTN;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StSend = 2'd2
  } state_e;

  // Release characters for bits 0..15; a press is the same letter in upper case.
  localparam logic [7:0] CHAR_TBL [NBTN] = '{
    8'h64, 8'h75, 8'h6c, 8'h72, 8'h66, 8'h68, 8'h6d, 8'h73,
    8'h74, 8'h61, 8'h62, 8'h76, 8'h77, 8'h78, 8'h79, 8'h7a
  };

  function automatic logic [7:0] btn_char(input logic [IDX_W-1:0] idx, input logic pressed);
    logic [7:0] c;
    c = CHAR_TBL[idx];
    return pressed ? (c - 8'h20) : c;
  endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// Report FIFO: DEPTH entries of {state, change}. Pointers wrap naturally because
// DEPTH is a power of two. The storage array is never reset; it is only read
// through rdata while the FIFO is non-empty.
module btn_evt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_en, pop_en;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  // Full/empty come from the registered count, so a push into a full FIFO is
  // refused even if a pop happens in the same cycle.
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/btn_evt_serializer.sv
// Turns button-change reports into a stream of single ASCII characters for a UART
// transmitter: one character per changed button, lowest bit first, upper case for
// a press and lower case for a release. Reports are queued in a small FIFO;
// reports arriving while it is full are dropped and counted in ovf_cnt.
module btn_evt_serializer
  import btn_evt_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NBTN-1:0] btn_rpt_state,
  input  logic [NBTN-1:0] btn_rpt_change,
  input  logic            btn_rpt_stb,
  output logic [7:0]      uart_data,
  output logic            uart_valid,
  input  logic            uart_ack,
  output logic [7:0]      ovf_cnt
);

  state_e             state_q, state_d;
  logic [NBTN-1:0]    work_state_q, work_state_d;
  logic [NBTN-1:0]    work_mask_q, work_mask_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic [7:0]         ovf_q;

  logic               rpt_valid;
  logic               fifo_pop, fifo_full, fifo_empty;
  logic [RPT_W-1:0]   fifo_rdata;
  logic [IDX_W-1:0]   lsb_idx;

  // A strobe with an empty change mask carries nothing to report.
  assign rpt_valid = btn_rpt_stb & (|btn_rpt_change);

  btn_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RPT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rpt_valid),
    .pop   (fifo_pop),
    .wdata ({btn_rpt_state, btn_rpt_change}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Lowest set bit of the working mask; descending scan so the lowest index wins.
  always_comb begin
    lsb_idx = '0;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (work_mask_q[i]) lsb_idx = IDX_W'(i);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (!fifo_empty) state_d = StScan;
      StScan: state_d = (work_mask_q == '0) ? StIdle : StSend;
      StSend: if (valid_q && uart_ack) state_d = StScan;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: FIFO pop, working registers and the registered UART character.
  always_comb begin
    fifo_pop     = 1'b0;
    work_state_d = work_state_q;
    work_mask_d  = work_mask_q;
    data_d       = data_q;
    valid_d      = valid_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          work_state_d = fifo_rdata[RPT_W-1:NBTN];
          work_mask_d  = fifo_rdata[NBTN-1:0];
        end
      end
      StScan: begin
        if (work_mask_q != '0) begin
          data_d               = btn_char(lsb_idx, work_state_q[lsb_idx]);
          valid_d              = 1'b1;
          work_mask_d[lsb_idx] = 1'b0;
        end
      end
      StSend: begin
        if (valid_q && uart_ack) valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers behind the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_state_q <= '0;
      work_mask_q  <= '0;
      data_q       <= 8'h00;
      valid_q      <= 1'b0;
    end else begin
      work_state_q <= work_state_d;
      work_mask_q  <= work_mask_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
    end
  end

  // Saturating drop counter; a report is dropped when the FIFO is already full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 8'h00;
    end else if (rpt_valid && fifo_full && (ovf_q != 8'hff)) begin
      ovf_q <= ovf_q + 8'h01;
    end
  end

  assign uart_data  = data_q;
  assign uart_valid = valid_q;
  assign ovf_cnt    = ovf_q;

endmodule
